// File: rtl/ssd_pkg.sv
// Shared constants, state encoding and helpers for the seven-segment display controller.
// Cathodes are active-low and ordered {g,f,e,d,c,b,a}.
package ssd_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 62; i++) begin
         if ((64'd1 << i) < 64'(value)) r = i + 1;
      end
      return r;
   endfunction

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   function automatic logic [6:0] seg_digit(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ssd_display_ctrl_bin2bcd.sv
// Iterative double-dabble: one add-3/shift step per clock, DATA_W steps per conversion.
// done_o flags the cycle whose closing edge applies the final step, so bcd_o is final right after it.
module bin2bcd_seq
   import ssd_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int DIGITS = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [DATA_W-1:0]     bin_i,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o
);

   localparam int CNT_W = (clog2(DATA_W + 1) > 0) ? clog2(DATA_W + 1) : 1;

   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   bin_q, bin_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic [4*DIGITS-1:0] adj_s;

   assign done_o = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
   assign bcd_o  = bcd_q;

   // add-3 correction on every nibble that would overflow past 9 after the shift
   always_comb begin
      adj_s = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         else                         adj_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
   end

   // iteration control: load on start, then shift DATA_W times
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         bin_d  = bin_i;
         bcd_d  = '0;
      end else if (busy_q) begin
         {bcd_d, bin_d} = {adj_s[4*DIGITS-2:0], bin_q, 1'b0};
         cnt_d          = cnt_q + 1'b1;
         busy_d         = !done_o;
      end else begin
         busy_d = 1'b0;
      end
   end

   // state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         bin_q  <= '0;
         bcd_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
      end
   end

endmodule

// File: rtl/ssd_display_ctrl.sv
// Seven-segment controller: sequential BCD conversion, sign/overflow/blanking, multiplexed scan.
// A 1-deep pending buffer (last load wins) absorbs loads that arrive while a conversion is running.
module ssd_display_ctrl
   import ssd_pkg::*;
#(
   parameter int DATA_W     = 10,
   parameter int DIGITS     = 4,
   parameter int CLK_HZ     = 100_000_000,
   parameter int REFRESH_HZ = 750,
   parameter int BLANK_LZ   = 1
) (
   input  logic              clock_100Mhz,
   input  logic              reset,
   input  logic [DATA_W-1:0] bin_in,
   input  logic              negative,
   input  logic              load,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [DIGITS-1:0] anode_out,
   output logic [6:0]        BCD_ssd
);

   localparam int          TICK    = (CLK_HZ / REFRESH_HZ > 1) ? CLK_HZ / REFRESH_HZ : 2;
   localparam int          TICK_W  = (clog2(TICK) > 0) ? clog2(TICK) : 1;
   localparam int          IDX_W   = (clog2(DIGITS) > 0) ? clog2(DIGITS) : 1;
   localparam logic [63:0] LIM_POS = pow10(DIGITS);
   localparam logic [63:0] LIM_NEG = pow10(DIGITS - 1);

   state_e                   state_q, state_d;
   logic                     busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic                     pend_vld_q, pend_vld_d, pend_neg_q, pend_neg_d;
   logic [DATA_W-1:0]        pend_val_q, pend_val_d;
   logic                     cap_neg_q, cap_neg_d, cap_ovf_q, cap_ovf_d;
   logic [DIGITS-1:0][6:0]   disp_q, disp_d, disp_next_s;
   logic [TICK_W-1:0]        tick_cnt_q, tick_cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [DIGITS-1:0]        anode_q, anode_d;
   logic [6:0]               seg_q, seg_d;
   logic                     start_s, src_neg_s, tick_s, bcd_done_s;
   logic [DATA_W-1:0]        src_val_s;
   logic [4*DIGITS-1:0]      bcd_s;
   int                       msd_s;

   bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bin2bcd (
      .clk_i   (clock_100Mhz),
      .rst_ni  (reset),
      .start_i (start_s),
      .bin_i   (src_val_s),
      .done_o  (bcd_done_s),
      .bcd_o   (bcd_s)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = ovf_q;
   assign anode_out = anode_q;
   assign BCD_ssd   = seg_q;

   // glyphs for the finished conversion: overflow, sign placement and leading-zero blanking
   always_comb begin
      msd_s = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_s[4*i +: 4] != 4'd0) msd_s = i;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (cap_ovf_q)                        disp_next_s[i] = SEG_MINUS;
         else if (BLANK_LZ != 0) begin
            if (i <= msd_s)                    disp_next_s[i] = seg_digit(bcd_s[4*i +: 4]);
            else if (cap_neg_q && i == msd_s + 1) disp_next_s[i] = SEG_MINUS;
            else                               disp_next_s[i] = SEG_BLANK;
         end
         else if (cap_neg_q && i == DIGITS - 1) disp_next_s[i] = SEG_MINUS;
         else                                  disp_next_s[i] = seg_digit(bcd_s[4*i +: 4]);
      end
   end

   // conversion FSM, capture and pending buffer
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;
      disp_d     = disp_q;
      cap_neg_d  = cap_neg_q;
      cap_ovf_d  = cap_ovf_q;
      pend_vld_d = pend_vld_q;
      pend_val_d = pend_val_q;
      pend_neg_d = pend_neg_q;
      start_s    = 1'b0;
      src_val_s  = pend_vld_q ? pend_val_q : bin_in;
      src_neg_s  = pend_vld_q ? pend_neg_q : negative;
      case (state_q)
         ST_IDLE: begin
            if (pend_vld_q || load) begin
               start_s   = 1'b1;
               busy_d    = 1'b1;
               state_d   = ST_SHIFT;
               cap_neg_d = src_neg_s && (src_val_s != '0);
               cap_ovf_d = src_neg_s ? (64'(src_val_s) >= LIM_NEG) : (64'(src_val_s) >= LIM_POS);
            end else begin
               busy_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (bcd_done_s) state_d = ST_COMMIT;
            else            state_d = ST_SHIFT;
         end
         ST_COMMIT: begin
            disp_d  = disp_next_s;
            ovf_d   = cap_ovf_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
      // a load that cannot start now is parked; IDLE with a pending value re-parks a coincident load
      if (load && (state_q != ST_IDLE || pend_vld_q)) begin
         pend_vld_d = 1'b1;
         pend_val_d = bin_in;
         pend_neg_d = negative;
      end else if (state_q == ST_IDLE) begin
         pend_vld_d = 1'b0;
      end else begin
         pend_vld_d = pend_vld_q;
      end
   end

   // free-running digit scan
   always_comb begin
      tick_s     = (tick_cnt_q == TICK_W'(TICK - 1));
      tick_cnt_d = tick_s ? '0 : tick_cnt_q + 1'b1;
      anode_d    = anode_q;
      seg_d      = seg_q;
      idx_d      = idx_q;
      if (tick_s) begin
         anode_d = ~(DIGITS'(1) << idx_q);
         seg_d   = disp_q[idx_q];
         idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
         idx_d = idx_q;
      end
   end

   // state registers
   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_val_q <= '0;
         pend_neg_q <= 1'b0;
         cap_neg_q  <= 1'b0;
         cap_ovf_q  <= 1'b0;
         disp_q     <= {DIGITS{SEG_BLANK}};
         tick_cnt_q <= '0;
         idx_q      <= '0;
         anode_q    <= '1;
         seg_q      <= SEG_BLANK;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         pend_vld_q <= pend_vld_d;
         pend_val_q <= pend_val_d;
         pend_neg_q <= pend_neg_d;
         cap_neg_q  <= cap_neg_d;
         cap_ovf_q  <= cap_ovf_d;
         disp_q     <= disp_d;
         tick_cnt_q <= tick_cnt_d;
         idx_q      <= idx_d;
         anode_q    <= anode_d;
         seg_q      <= seg_d;
      end
   end

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Directed bench for ssd_display_ctrl: one instance with leading-zero blanking, one without.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ssd_display_ctrl;

   localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
   localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
   localparam logic [6:0] SM = 7'h3F, SB = 7'h7F;

   logic        clk, rst_n, ld, neg;
   logic [9:0]  bin;
   logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
   logic [3:0]  an_a, an_b;
   logic [6:0]  seg_a, seg_b;
   logic [3:0][6:0] disp_a, disp_b;
   int checks, failures;

   ssd_display_ctrl #(.DATA_W(10), .DIGITS(4), .CLK_HZ(1000), .REFRESH_HZ(250), .BLANK_LZ(1)) dut_a (
      .clock_100Mhz(clk), .reset(rst_n), .bin_in(bin), .negative(neg), .load(ld),
      .busy(busy_a), .done(done_a), .overflow(ovf_a), .anode_out(an_a), .BCD_ssd(seg_a));

   ssd_display_ctrl #(.DATA_W(10), .DIGITS(4), .CLK_HZ(1000), .REFRESH_HZ(250), .BLANK_LZ(0)) dut_b (
      .clock_100Mhz(clk), .reset(rst_n), .bin_in(bin), .negative(neg), .load(ld),
      .busy(busy_b), .done(done_b), .overflow(ovf_b), .anode_out(an_b), .BCD_ssd(seg_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic capture_display();
      disp_a = {4{7'h55}};
      disp_b = {4{7'h55}};
      repeat (20) @(negedge clk);
      repeat (16) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (an_a == ~(4'b0001 << i)) disp_a[i] = seg_a;
            if (an_b == ~(4'b0001 << i)) disp_b[i] = seg_b;
         end
      end
   endtask

   task automatic do_load(input logic [9:0] value, input logic sign);
      int n;
      @(negedge clk);
      ld = 1'b1; bin = value; neg = sign;
      @(negedge clk);
      ld = 1'b0;
      n = 0;
      while (done_a !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done_a !== 1'b1) begin
         failures++;
         $display("FAIL load_done_timeout value=%0d: done=%b required=1", value, done_a);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ld = 1'b0; neg = 1'b0; bin = 10'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({busy_a, done_a, ovf_a, an_a, seg_a} !== {3'b000, 4'b1111, SB}) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b an=%b seg=%h", busy_a, done_a, ovf_a, an_a, seg_a);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (an_a !== 4'b1111 || an_b !== 4'b1111 || busy_b !== 1'b0) begin
         failures++;
         $display("FAIL pre_tick_anode: got a=%b b=%b required 1111", an_a, an_b);
      end
      @(negedge clk);
      checks++;
      if (an_a !== 4'b1110 || seg_a !== SB) begin
         failures++;
         $display("FAIL first_tick: got an=%b seg=%h required an=1110 seg=%h", an_a, seg_a, SB);
      end
   endtask

   task automatic test_latency();
      int bad_busy;
      bad_busy = 0;
      @(negedge clk);
      ld = 1'b1; bin = 10'd987; neg = 1'b0;
      @(negedge clk);
      ld = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         if (busy_a !== 1'b1 || done_a !== 1'b0) bad_busy++;
         @(negedge clk);
      end
      checks++;
      if (bad_busy != 0) begin
         failures++;
         $display("FAIL latency_busy_window: %0d cycles wrong, required 0", bad_busy);
      end
      checks++;
      if (done_a !== 1'b1 || busy_a !== 1'b0) begin
         failures++;
         $display("FAIL latency_done_edge: got done=%b busy=%b required done=1 busy=0", done_a, busy_a);
      end
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0) begin
         failures++;
         $display("FAIL done_single_pulse: got done=%b required 0", done_a);
      end
      capture_display();
      checks++;
      if (disp_a !== {SB, S9, S8, S7} || ovf_a !== 1'b0) begin
         failures++;
         $display("FAIL display_987: got %h ovf=%b required %h", disp_a, ovf_a, {SB, S9, S8, S7});
      end
   endtask

   task automatic test_sign();
      do_load(10'd5, 1'b1);
      capture_display();
      checks++;
      if (disp_a !== {SB, SB, SM, S5}) begin
         failures++;
         $display("FAIL neg5_blank_lz: got %h required %h", disp_a, {SB, SB, SM, S5});
      end
      checks++;
      if (disp_b !== {SM, S0, S0, S5}) begin
         failures++;
         $display("FAIL neg5_show_lz: got %h required %h", disp_b, {SM, S0, S0, S5});
      end
      do_load(10'd0, 1'b1);
      capture_display();
      checks++;
      if (disp_a !== {SB, SB, SB, S0} || disp_b !== {S0, S0, S0, S0}) begin
         failures++;
         $display("FAIL neg_zero: got a=%h b=%h", disp_a, disp_b);
      end
   endtask

   task automatic test_overflow();
      do_load(10'd1023, 1'b0);
      capture_display();
      checks++;
      if (disp_a !== {S1, S0, S2, S3} || ovf_a !== 1'b0 || disp_b !== {S1, S0, S2, S3}) begin
         failures++;
         $display("FAIL pos_1023: got a=%h b=%h ovf=%b required %h ovf=0", disp_a, disp_b, ovf_a, {S1, S0, S2, S3});
      end
      do_load(10'd999, 1'b1);
      capture_display();
      checks++;
      if (disp_a !== {SM, S9, S9, S9} || ovf_a !== 1'b0) begin
         failures++;
         $display("FAIL neg_999_edge: got %h ovf=%b required %h ovf=0", disp_a, ovf_a, {SM, S9, S9, S9});
      end
      do_load(10'd1000, 1'b1);
      checks++;
      if (ovf_a !== 1'b1 || ovf_b !== 1'b1) begin
         failures++;
         $display("FAIL neg_1000_ovf: got a=%b b=%b required 1", ovf_a, ovf_b);
      end
      do_load(10'd1023, 1'b1);
      capture_display();
      checks++;
      if (disp_a !== {SM, SM, SM, SM} || ovf_a !== 1'b1) begin
         failures++;
         $display("FAIL neg_1023_ovf: got %h ovf=%b required %h ovf=1", disp_a, ovf_a, {SM, SM, SM, SM});
      end
   endtask

   task automatic test_back_to_back();
      int ndone, first_k, last_k;
      logic busy11, busy12;
      ndone = 0; first_k = -1; last_k = -1; busy11 = 1'bx; busy12 = 1'bx;
      @(negedge clk);
      ld = 1'b1; bin = 10'd12; neg = 1'b0;
      @(negedge clk);
      ld = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done_a === 1'b1) begin
            ndone++;
            if (ndone == 1) first_k = k;
            else last_k = k;
         end
         if (k == 11) busy11 = busy_a;
         if (k == 12) busy12 = busy_a;
         if (k == 2) begin ld = 1'b1; bin = 10'd34; end
         else if (k == 3) bin = 10'd56;
         else if (k == 4) ld = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (ndone != 2 || first_k != 11 || last_k != 23) begin
         failures++;
         $display("FAIL b2b_done_pulses: got count=%0d at %0d,%0d required 2 at 11,23", ndone, first_k, last_k);
      end
      checks++;
      if (busy11 !== 1'b0 || busy12 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_busy_gap: got %b%b required 01", busy11, busy12);
      end
      capture_display();
      checks++;
      if (disp_a !== {SB, SB, S5, S6}) begin
         failures++;
         $display("FAIL b2b_display: got %h required %h", disp_a, {SB, SB, S5, S6});
      end
   endtask

   task automatic test_reset_mid();
      int ndone;
      ndone = 0;
      @(negedge clk);
      ld = 1'b1; bin = 10'd999; neg = 1'b0;
      @(negedge clk);
      ld = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy_a, done_a, ovf_a, an_a, seg_a} !== {3'b000, 4'b1111, SB}) begin
         failures++;
         $display("FAIL midreset_outputs: got busy=%b done=%b ovf=%b an=%b seg=%h", busy_a, done_a, ovf_a, an_a, seg_a);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done_a === 1'b1 || done_b === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0 || busy_a !== 1'b0) begin
         failures++;
         $display("FAIL midreset_no_done: got %0d done pulses busy=%b required 0", ndone, busy_a);
      end
      capture_display();
      checks++;
      if (disp_a !== {SB, SB, SB, SB} || disp_b !== {SB, SB, SB, SB}) begin
         failures++;
         $display("FAIL midreset_blank: got a=%h b=%h required all %h", disp_a, disp_b, SB);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_latency();
      test_sign();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
